// File: rtl/eca_pkg.sv
// Shared defaults and bank state encoding for the erasure coding input buffer.
package eca_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_K      = 4;
  localparam int DEF_DEPTH  = 16;

  typedef enum logic {
    BANK_FREE = 1'b0,
    BANK_FULL = 1'b1
  } bank_state_e;

endpackage

// File: rtl/eca_inbuf_bank.sv
// One buffer bank: K word RAMs sharing a single write port and a single
// row-read port; the read of word r from every chunk is registered together.
module eca_inbuf_bank
  import eca_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int K      = DEF_K,
  parameter int DEPTH  = DEF_DEPTH,
  localparam int ROW_W   = $clog2(DEPTH),
  localparam int CHUNK_W = (K > 1) ? $clog2(K) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr_en,
  input  logic [CHUNK_W-1:0]  wr_chunk,
  input  logic [ROW_W-1:0]    wr_row,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic                rd_en,
  input  logic [ROW_W-1:0]    rd_row,
  output logic [K*DATA_W-1:0] rd_data
);

  for (genvar c = 0; c < K; c++) begin : g_chunk
    logic [DATA_W-1:0] ram [DEPTH];
    logic [DATA_W-1:0] rd_q;

    // Store a host word into this chunk's RAM when the chunk is addressed.
    always_ff @(posedge clk) begin
      if (wr_en && (wr_chunk == CHUNK_W'(c))) begin
        ram[wr_row] <= wr_data;
      end
    end

    // Registered row read; holds its value between reads.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rd_q <= '0;
      end else if (rd_en) begin
        rd_q <= ram[rd_row];
      end
    end

    assign rd_data[c*DATA_W +: DATA_W] = rd_q;
  end

endmodule

// File: rtl/eca_inbuf.sv
// Ping-pong input buffer: host fills one bank while the engine reads the other.
// Banks are FREE (owned by host) or FULL (owned by engine).
module eca_inbuf
  import eca_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int K      = DEF_K,
  parameter int DEPTH  = DEF_DEPTH,
  localparam int ROW_W  = $clog2(DEPTH),
  localparam int ADDR_W = $clog2(K*DEPTH)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                sw_clr,
  input  logic                inbuf_wr_req,
  input  logic [ADDR_W-1:0]   inbuf_wr_addr,
  input  logic [DATA_W-1:0]   inbuf_wr_data,
  input  logic                inbuf_wr_last,
  output logic                inbuf_wr_ready,
  input  logic                eng_rd_req,
  input  logic [ROW_W-1:0]    eng_rd_row,
  output logic [K*DATA_W-1:0] eng_rd_data,
  output logic                eng_rd_val,
  input  logic                eng_done,
  output logic                inbuf_bank_ready,
  output logic [ADDR_W:0]     inbuf_wr_cnt,
  output logic [1:0]          inbuf_err
);

  localparam int CHUNK_W = (K > 1) ? $clog2(K) : 1;
  localparam int WORDS   = K * DEPTH;

  bank_state_e         bank_st [2];
  bank_state_e         st_nxt  [2];
  logic                wr_bank;
  logic                rd_bank;
  logic                rd_sel;
  logic                rd_val_q;
  logic [ADDR_W:0]     wr_cnt_q;
  logic [1:0]          err_q;

  logic                wr_acc;
  logic                wr_close;
  logic                rd_acc;
  logic                done_acc;
  logic                addr_ok;
  logic [31:0]         addr_ext;
  logic [CHUNK_W-1:0]  wr_chunk;
  logic [ROW_W-1:0]    wr_row;
  logic [1:0]          bank_wr_en;
  logic [1:0]          bank_rd_en;
  logic [K*DATA_W-1:0] bank_data [2];

  assign inbuf_wr_ready   = (bank_st[wr_bank] == BANK_FREE);
  assign inbuf_bank_ready = (bank_st[rd_bank] == BANK_FULL);

  assign wr_acc   = inbuf_wr_req & inbuf_wr_ready;
  assign wr_close = wr_acc & inbuf_wr_last;
  assign rd_acc   = eng_rd_req & inbuf_bank_ready;
  assign done_acc = eng_done & inbuf_bank_ready;

  // Split host word address into chunk and row; flag addresses past the stripe.
  always_comb begin
    addr_ext = 32'(inbuf_wr_addr);
    wr_chunk = CHUNK_W'(addr_ext / DEPTH);
    wr_row   = ROW_W'(addr_ext % DEPTH);
    addr_ok  = (addr_ext < WORDS);
  end

  // Bank ownership hand-over; a closing write and a release always hit
  // different banks because one needs FREE and the other FULL.
  always_comb begin
    st_nxt[0] = bank_st[0];
    st_nxt[1] = bank_st[1];
    if (wr_close) st_nxt[wr_bank] = BANK_FULL;
    if (done_acc) st_nxt[rd_bank] = BANK_FREE;
  end

  // State, pointers, write count, sticky errors and read-valid pipeline.
  // rd_sel survives sw_clr so eng_rd_data keeps holding its last value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_st[0] <= BANK_FREE;
      bank_st[1] <= BANK_FREE;
      wr_bank    <= 1'b0;
      rd_bank    <= 1'b0;
      wr_cnt_q   <= '0;
      err_q      <= '0;
      rd_val_q   <= 1'b0;
      rd_sel     <= 1'b0;
    end else if (sw_clr) begin
      bank_st[0] <= BANK_FREE;
      bank_st[1] <= BANK_FREE;
      wr_bank    <= 1'b0;
      rd_bank    <= 1'b0;
      wr_cnt_q   <= '0;
      err_q      <= '0;
      rd_val_q   <= 1'b0;
    end else begin
      bank_st[0] <= st_nxt[0];
      bank_st[1] <= st_nxt[1];
      if (wr_close) wr_bank <= ~wr_bank;
      if (done_acc) rd_bank <= ~rd_bank;
      if (wr_close) begin
        wr_cnt_q <= '0;
      end else if (wr_acc) begin
        wr_cnt_q <= wr_cnt_q + 1'b1;
      end
      if (inbuf_wr_req && !inbuf_wr_ready)             err_q[0] <= 1'b1;
      if ((eng_rd_req || eng_done) && !inbuf_bank_ready) err_q[1] <= 1'b1;
      rd_val_q <= rd_acc;
      if (rd_acc) rd_sel <= rd_bank;
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    assign bank_wr_en[b] = wr_acc & addr_ok & (wr_bank == 1'(b)) & ~sw_clr;
    assign bank_rd_en[b] = rd_acc & (rd_bank == 1'(b)) & ~sw_clr;

    eca_inbuf_bank #(
      .DATA_W (DATA_W),
      .K      (K),
      .DEPTH  (DEPTH)
    ) u_bank (
      .clk      (clk),
      .rst_n    (rst_n),
      .wr_en    (bank_wr_en[b]),
      .wr_chunk (wr_chunk),
      .wr_row   (wr_row),
      .wr_data  (inbuf_wr_data),
      .rd_en    (bank_rd_en[b]),
      .rd_row   (eng_rd_row),
      .rd_data  (bank_data[b])
    );
  end

  assign eng_rd_data  = bank_data[rd_sel];
  assign eng_rd_val   = rd_val_q;
  assign inbuf_wr_cnt = wr_cnt_q;
  assign inbuf_err    = err_q;

endmodule

// File: tb/tb_eca_inbuf.sv
// Bench for eca_inbuf: directed scenarios plus randomized traffic against a
// behavioural model of the two-bank ownership rules.
module tb_eca_inbuf;

  localparam int DW = 32;
  localparam int KK = 4;
  localparam int DP = 16;
  localparam int AW = 6;
  localparam int NW = KK * DP;

  logic           clk;
  logic           rst_n;
  logic           sw_clr;
  logic           inbuf_wr_req;
  logic [AW-1:0]  inbuf_wr_addr;
  logic [DW-1:0]  inbuf_wr_data;
  logic           inbuf_wr_last;
  logic           inbuf_wr_ready;
  logic           eng_rd_req;
  logic [3:0]     eng_rd_row;
  logic [KK*DW-1:0] eng_rd_data;
  logic           eng_rd_val;
  logic           eng_done;
  logic           inbuf_bank_ready;
  logic [AW:0]    inbuf_wr_cnt;
  logic [1:0]     inbuf_err;

  int n_checks = 0;
  int n_fail   = 0;

  eca_inbuf #(.DATA_W(DW), .K(KK), .DEPTH(DP)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .sw_clr           (sw_clr),
    .inbuf_wr_req     (inbuf_wr_req),
    .inbuf_wr_addr    (inbuf_wr_addr),
    .inbuf_wr_data    (inbuf_wr_data),
    .inbuf_wr_last    (inbuf_wr_last),
    .inbuf_wr_ready   (inbuf_wr_ready),
    .eng_rd_req       (eng_rd_req),
    .eng_rd_row       (eng_rd_row),
    .eng_rd_data      (eng_rd_data),
    .eng_rd_val       (eng_rd_val),
    .eng_done         (eng_done),
    .inbuf_bank_ready (inbuf_bank_ready),
    .inbuf_wr_cnt     (inbuf_wr_cnt),
    .inbuf_err        (inbuf_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [DW-1:0]    m_mem [2][NW];
  bit               m_full [2];
  bit               m_wb;
  bit               m_rb;
  int               m_cnt;
  logic [1:0]       m_err;
  bit               m_val;
  logic [KK*DW-1:0] m_data;

  always @(posedge clk or negedge rst_n) begin
    bit wr_ok;
    bit rd_ok;
    bit wb;
    bit rb;
    if (!rst_n) begin
      m_full[0] = 0; m_full[1] = 0;
      m_wb = 0; m_rb = 0; m_cnt = 0; m_err = 2'b00; m_val = 0;
      m_data = '0;
    end else begin
      wr_ok = !m_full[m_wb];
      rd_ok = m_full[m_rb];
      wb = m_wb;
      rb = m_rb;
      if (sw_clr) begin
        m_full[0] = 0; m_full[1] = 0;
        m_wb = 0; m_rb = 0; m_cnt = 0; m_err = 2'b00; m_val = 0;
      end else begin
        m_val = 0;
        if (eng_rd_req && rd_ok) begin
          for (int c = 0; c < KK; c++)
            m_data[c*DW +: DW] = m_mem[rb][c*DP + int'(eng_rd_row)];
          m_val = 1;
        end
        if ((eng_rd_req || eng_done) && !rd_ok) m_err[1] = 1'b1;
        if (inbuf_wr_req && !wr_ok) m_err[0] = 1'b1;
        if (inbuf_wr_req && wr_ok) begin
          if (int'(inbuf_wr_addr) < NW) m_mem[wb][int'(inbuf_wr_addr)] = inbuf_wr_data;
          m_cnt++;
          if (inbuf_wr_last) begin
            m_full[wb] = 1;
            m_wb = !wb;
            m_cnt = 0;
          end
        end
        if (eng_done && rd_ok) begin
          m_full[rb] = 0;
          m_rb = !rb;
        end
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("wr_ready",   128'(inbuf_wr_ready),   128'(!m_full[m_wb]));
    chk("bank_ready", 128'(inbuf_bank_ready), 128'(m_full[m_rb]));
    chk("wr_cnt",     128'(inbuf_wr_cnt),     128'(m_cnt));
    chk("err",        128'(inbuf_err),        128'(m_err));
    chk("rd_val",     128'(eng_rd_val),       128'(m_val));
    chk("rd_data",    eng_rd_data,            m_data);
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int a, input logic [DW-1:0] d, input bit last);
    inbuf_wr_req  = 1'b1;
    inbuf_wr_addr = AW'(a);
    inbuf_wr_data = d;
    inbuf_wr_last = last;
    tick();
    inbuf_wr_req  = 1'b0;
    inbuf_wr_last = 1'b0;
  endtask

  task automatic rd(input int r);
    eng_rd_req = 1'b1;
    eng_rd_row = 4'(r);
    tick();
    eng_rd_req = 1'b0;
  endtask

  task automatic done_pulse();
    eng_done = 1'b1;
    tick();
    eng_done = 1'b0;
  endtask

  task automatic clr_pulse();
    sw_clr = 1'b1;
    tick();
    sw_clr = 1'b0;
  endtask

  task automatic stripe(input logic [DW-1:0] base);
    for (int a = 0; a < NW; a++) wr(a, base + DW'(a), a == NW - 1);
  endtask

  task automatic chk_idle(input string nm);
    chk({nm, "_cnt"},    128'(inbuf_wr_cnt),     128'(0));
    chk({nm, "_wrrdy"},  128'(inbuf_wr_ready),   128'(1));
    chk({nm, "_bkrdy"},  128'(inbuf_bank_ready), 128'(0));
    chk({nm, "_err"},    128'(inbuf_err),        128'(0));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [KK*DW-1:0] exp;
    int idx;
    int mult;
    int off;
    bit ovw;

    rst_n = 1'b0; sw_clr = 1'b0;
    inbuf_wr_req = 1'b0; inbuf_wr_addr = '0; inbuf_wr_data = '0; inbuf_wr_last = 1'b0;
    eng_rd_req = 1'b0; eng_rd_row = '0; eng_done = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk_idle("rst");
    chk("rst_val", 128'(eng_rd_val), 128'(0));

    // 1: stripe with data = addr, then read row 5
    for (int a = 0; a < NW; a++) begin
      if (a == NW - 1) chk("t1_cnt63", 128'(inbuf_wr_cnt), 128'(63));
      wr(a, DW'(a), a == NW - 1);
    end
    chk("t1_cnt_clr",  128'(inbuf_wr_cnt),     128'(0));
    chk("t1_bank_rdy", 128'(inbuf_bank_ready), 128'(1));
    chk("t1_wr_rdy",   128'(inbuf_wr_ready),   128'(1));
    rd(5);
    chk("t1_val",  128'(eng_rd_val), 128'(1));
    chk("t1_data", eng_rd_data, {32'h35, 32'h25, 32'h15, 32'h05});
    tick();
    chk("t1_val_drop", 128'(eng_rd_val), 128'(0));

    // 2: both banks full, dropped write, release
    stripe(32'h100);
    chk("t2_wr_rdy0", 128'(inbuf_wr_ready), 128'(0));
    wr(3, 32'hDEAD_BEEF, 1'b0);
    chk("t2_err", 128'(inbuf_err), 128'(2'b01));
    chk("t2_cnt", 128'(inbuf_wr_cnt), 128'(0));
    done_pulse();
    chk("t2_wr_rdy1", 128'(inbuf_wr_ready), 128'(1));
    rd(0);
    chk("t2_data", eng_rd_data, {32'h130, 32'h120, 32'h110, 32'h100});

    // 3: back-to-back rows 0..15
    for (int r = 0; r < DP; r++) begin
      eng_rd_req = 1'b1;
      eng_rd_row = 4'(r);
      tick();
      exp = {DW'(32'h130 + r), DW'(32'h120 + r), DW'(32'h110 + r), DW'(32'h100 + r)};
      chk("t3_val",  128'(eng_rd_val), 128'(1));
      chk("t3_data", eng_rd_data, exp);
    end
    eng_rd_req = 1'b0;
    done_pulse();
    clr_pulse();

    // 4: read and release with no full bank
    eng_rd_req = 1'b1; eng_done = 1'b1; eng_rd_row = 4'd0;
    tick();
    eng_rd_req = 1'b0; eng_done = 1'b0;
    chk("t4_val",  128'(eng_rd_val), 128'(0));
    chk("t4_err",  128'(inbuf_err),  128'(2'b10));
    chk("t4_hold", eng_rd_data, {32'h13f, 32'h12f, 32'h11f, 32'h10f});
    chk("t4_bank_rdy", 128'(inbuf_bank_ready), 128'(0));

    // 5: closing write into bank1 coincides with release of bank0
    clr_pulse();
    stripe(32'h200);
    for (int a = 0; a < NW - 1; a++) wr(a, DW'(32'h300 + a), 1'b0);
    eng_done = 1'b1;
    wr(NW - 1, DW'(32'h300 + NW - 1), 1'b1);
    eng_done = 1'b0;
    chk("t5_bank_rdy", 128'(inbuf_bank_ready), 128'(1));
    chk("t5_wr_rdy",   128'(inbuf_wr_ready),   128'(1));
    chk("t5_err",      128'(inbuf_err),        128'(0));
    rd(2);
    chk("t5_data", eng_rd_data, {32'h332, 32'h322, 32'h312, 32'h302});

    // 6: partial stripe discarded by sw_clr and by reset
    clr_pulse();
    for (int a = 0; a < 10; a++) wr(a, DW'(32'h400 + a), 1'b0);
    clr_pulse();
    chk_idle("t6_clr");
    for (int a = 0; a < 10; a++) wr(a, DW'(32'h500 + a), 1'b0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk_idle("t6_rst");
    for (int a = 0; a < NW; a++) wr(a, DW'(a) ^ 32'hA5A5_0000, a == NW - 1);
    rd(7);
    chk("t6_data", eng_rd_data,
        {32'hA5A5_0037, 32'hA5A5_0027, 32'hA5A5_0017, 32'hA5A5_0007});

    // Randomized traffic: host streams permuted full stripes with occasional
    // overwrites; engine reads/releases randomly; rare soft clears.
    clr_pulse();
    idx  = 0;
    mult = int'($urandom_range(0, 31)) * 2 + 1;
    off  = int'($urandom_range(0, NW - 1));
    repeat (2000) begin
      sw_clr = ($urandom_range(0, 149) == 0);
      ovw = ($urandom_range(0, 7) == 0) && (idx < NW - 1);
      inbuf_wr_req = ($urandom_range(0, 3) != 0);
      inbuf_wr_data = $urandom;
      if (ovw) begin
        inbuf_wr_addr = AW'($urandom_range(0, NW - 1));
        inbuf_wr_last = 1'b0;
      end else begin
        inbuf_wr_addr = AW'((idx * mult + off) % NW);
        inbuf_wr_last = (idx == NW - 1);
      end
      if (sw_clr) begin
        idx = 0;
      end else if (inbuf_wr_req && !m_full[m_wb] && !ovw) begin
        if (idx == NW - 1) begin
          idx  = 0;
          mult = int'($urandom_range(0, 31)) * 2 + 1;
          off  = int'($urandom_range(0, NW - 1));
        end else begin
          idx++;
        end
      end
      if (m_full[m_rb]) begin
        eng_rd_req = ($urandom_range(0, 1) == 1);
        eng_done   = ($urandom_range(0, 11) == 0);
      end else begin
        eng_rd_req = ($urandom_range(0, 31) == 0);
        eng_done   = ($urandom_range(0, 31) == 0);
      end
      eng_rd_row = 4'($urandom_range(0, DP - 1));
      tick();
    end
    sw_clr = 1'b0; inbuf_wr_req = 1'b0; inbuf_wr_last = 1'b0;
    eng_rd_req = 1'b0; eng_done = 1'b0;
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
